tls_monitor: RTL and testbench
==============================

Name: tls_monitor

Overview:
- Passive checker that sits on the traffic-light controller's output side and watches the Gout/Yout/Rout lines.
- Reconstructs the light sequence and measures each phase length in clock cycles.
- Compares each measured length against the programmed Gin/Yin/Rin durations and raises sticky errors for illegal light codes, illegal sequences and duration mismatches.
- Used in-system as a safety watchdog and in the bench as the scoreboard for the controller.

Parameters:
- W, 8, width of the phase-length counter and of the measured-duration outputs.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Set  in  1  same Set strobe as the controller; latches programmed durations
- Stop  in  1  same Stop as the controller; marks the current phase disturbed
- Jump  in  1  same Jump as the controller; marks the current phase disturbed
- Gin  in  4  programmed green duration
- Yin  in  4  programmed yellow duration
- Rin  in  4  programmed red duration
- Gl  in  1  observed green light
- Yl  in  1  observed yellow light
- Rl  in  1  observed red light
- err_clr  in  1  clears the sticky error flags
- Gmeas  out  W  last measured green length
- Ymeas  out  W  last measured yellow length
- Rmeas  out  W  last measured red length
- meas_valid  out  1  one-cycle pulse when a phase length is written
- dur_err  out  1  sticky duration-mismatch flag
- seq_err  out  1  sticky illegal-sequence flag
- onehot_err  out  1  sticky illegal-code flag
- err_phase  out  3  {G,Y,R} code of the phase that last set dur_err
- round_cnt  out  8  completed G-Y-R rounds (optional feature)

Behaviour:
- Reset (reset=0, async): all outputs are 0, state is IDLE, run_len=0, disturbed=1, and programmed registers G_t/Y_t/R_t are 0.
- Set=1 (synchronous, highest priority after reset): G_t/Y_t/R_t are loaded from Gin/Yin/Rin, state goes to IDLE, run_len=0, disturbed=1. Measured outputs and error flags are unchanged.
- Code decoding: {Gl,Yl,Rl} is sampled every edge. Legal codes are 100, 010 and 001.
  - Any other code sets onehot_err.
  - An illegal code is otherwise ignored: no state change, and run_len keeps counting.
- States are IDLE, G, Y and R.
  - IDLE: on the first legal code, enter the matching state with run_len=1. No measurement is made on this entry.
  - In G/Y/R, same code as the state: run_len increments and saturates at 2^W-1.
  - In G/Y/R, a different legal code (a transition) does all of the following at that edge:
    - run_len is written to the Xmeas output of the state being left.
    - meas_valid=1 for the following cycle.
    - The state changes and run_len=1.
    - disturbed is cleared to 0 unless Stop or Jump is high in that cycle.
- Duration check at each transition: if the phase was not disturbed, its programmed value is nonzero, and run_len != {0,prog}, then dur_err=1 and err_phase = code of the phase being left.
- Sequence check: G->Y, Y->R and R->G are legal. X->R is also legal when disturbed=1 (Jump). Any other transition sets seq_err. The monitor still follows the new code after a sequence error.
- disturbed is set to 1 in any cycle where Stop or Jump is high, and stays set until the next transition. The first phase after reset or Set is always disturbed.
- err_clr=1 clears dur_err, seq_err, onehot_err and err_phase. If a new error is detected in the same cycle, the new error wins.
- Priority order: reset > Set > err_clr/error detection > normal counting.
- Timing: a G phase of N cycles yields Gmeas=N, which equals Gin for the controller.

Optional Feature:
- TLS_MON_ROUND_EN defined: round_cnt increments on every R->G transition and wraps at 255. It is cleared by reset and by Set.
- TLS_MON_ROUND_EN undefined: no counter logic is built and round_cnt is tied to 0.

Test Plan:
- Set with Gin=3, Yin=2, Rin=4, then drive G×3, Y×2, R×4, G×3, Y×2 -> meas_valid pulses 4 times; Gmeas=3, Ymeas=2, Rmeas=4; no errors.
- After one clean round, hold G for 5 cycles with Gin=3 -> dur_err=1 and err_phase=100 at the G->Y transition.
- Pulse Jump during G, then drive R -> seq_err=0, no dur_err for the short G, Gmeas equals the actual length.
- Drive G->R with no Jump or Stop in the phase -> seq_err=1. Then pulse err_clr -> seq_err=0.
- Drive code 110 for 1 cycle mid-Y -> onehot_err=1, and Ymeas counts the illegal cycle.
- Assert reset low mid-R phase -> all outputs 0 immediately. After release, the first phase is unchecked. With TLS_MON_ROUND_EN, 3 full rounds give round_cnt=3.

Source files
------------

// File: rtl/tls_monitor.sv
// tls_monitor
// -----------
// Passive watchdog for the traffic-light controller outputs. It follows the
// observed {Gl,Yl,Rl} code and measures the length of every phase in clock
// cycles. Each measured length is compared against the programmed Gin/Yin/Rin
// duration. Sticky flags report three kinds of fault:
//   - illegal light codes
//   - illegal phase sequences
//   - duration mismatches
//
// Optional feature: define TLS_MON_ROUND_EN to build a counter of completed
// G-Y-R rounds. With it undefined, round_cnt is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   Set        latches Gin/Yin/Rin and restarts sequence tracking
//   Stop, Jump mark the current phase as disturbed (no duration check)
//   Gin/Yin/Rin programmed green/yellow/red durations
//   Gl/Yl/Rl   observed light lines
//   err_clr    clears the sticky error flags and err_phase
//   Gmeas/Ymeas/Rmeas  last measured phase lengths (W bits)
//   meas_valid one-cycle pulse after a phase length is written
//   dur_err, seq_err, onehot_err  sticky error flags
//   err_phase  {G,Y,R} code of the phase that last set dur_err
//   round_cnt  completed rounds (R->G transitions), optional
module tls_monitor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Set,
    input  logic         Stop,
    input  logic         Jump,
    input  logic [3:0]   Gin,
    input  logic [3:0]   Yin,
    input  logic [3:0]   Rin,
    input  logic         Gl,
    input  logic         Yl,
    input  logic         Rl,
    input  logic         err_clr,
    output logic [W-1:0] Gmeas,
    output logic [W-1:0] Ymeas,
    output logic [W-1:0] Rmeas,
    output logic         meas_valid,
    output logic         dur_err,
    output logic         seq_err,
    output logic         onehot_err,
    output logic [2:0]   err_phase,
    output logic [7:0]   round_cnt
);

    typedef enum logic [1:0] {IDLE, ST_G, ST_Y, ST_R} state_t;

    state_t       state, state_next, code_state;
    logic [W-1:0] run_len, run_len_next, run_len_inc;
    logic         disturbed, disturbed_next;
    logic [3:0]   g_t, y_t, r_t;
    logic [2:0]   code;
    logic         code_legal;
    logic         transition, seq_bad, dur_bad;
    logic [3:0]   prog_left;
    logic [2:0]   left_code;

    assign code = {Gl, Yl, Rl};

    // Next-state logic.
    // Illegal codes never move the FSM. They still count toward the current
    // phase length, because the lights are treated as staying in that phase.
    always_comb begin
        state_next     = state;
        run_len_next   = run_len;
        disturbed_next = disturbed | Stop | Jump;
        transition     = 1'b0;
        seq_bad        = 1'b0;
        dur_bad        = 1'b0;
        code_legal     = 1'b0;
        code_state     = IDLE;
        prog_left      = 4'd0;
        left_code      = 3'b000;
        run_len_inc    = (run_len == {W{1'b1}}) ? run_len : run_len + W'(1);

        case (code)
            3'b100:  begin code_legal = 1'b1; code_state = ST_G; end
            3'b010:  begin code_legal = 1'b1; code_state = ST_Y; end
            3'b001:  begin code_legal = 1'b1; code_state = ST_R; end
            default: ;
        endcase

        case (state)
            ST_G:    begin prog_left = g_t; left_code = 3'b100; end
            ST_Y:    begin prog_left = y_t; left_code = 3'b010; end
            ST_R:    begin prog_left = r_t; left_code = 3'b001; end
            default: ;
        endcase

        if (code_legal) begin
            if (state == IDLE) begin
                state_next   = code_state;
                run_len_next = W'(1);
            end else if (code_state == state) begin
                run_len_next = run_len_inc;
            end else begin
                transition     = 1'b1;
                state_next     = code_state;
                run_len_next   = W'(1);
                disturbed_next = Stop | Jump;
                // A jump may go to red from any phase. It is only accepted if
                // the phase being left was marked disturbed.
                seq_bad = !((state == ST_G && code_state == ST_Y) ||
                            (state == ST_Y && code_state == ST_R) ||
                            (state == ST_R && code_state == ST_G) ||
                            (code_state == ST_R && disturbed));
                // A zero programmed duration disables the check for that phase.
                dur_bad = !disturbed && (prog_left != 4'd0) &&
                          (run_len != W'(prog_left));
            end
        end else if (state != IDLE) begin
            run_len_next = run_len_inc;
        end
    end

    // State, measurement and error registers.
    // Set leaves the measured outputs and the error flags untouched.
    // Error flags are updated after the err_clr clear, so an error detected
    // in the same cycle as err_clr still ends up set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run_len    <= '0;
            disturbed  <= 1'b1;
            g_t        <= 4'd0;
            y_t        <= 4'd0;
            r_t        <= 4'd0;
            Gmeas      <= '0;
            Ymeas      <= '0;
            Rmeas      <= '0;
            meas_valid <= 1'b0;
            dur_err    <= 1'b0;
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
            err_phase  <= 3'b000;
        end else if (Set) begin
            g_t        <= Gin;
            y_t        <= Yin;
            r_t        <= Rin;
            state      <= IDLE;
            run_len    <= '0;
            disturbed  <= 1'b1;
            meas_valid <= 1'b0;
        end else begin
            state      <= state_next;
            run_len    <= run_len_next;
            disturbed  <= disturbed_next;
            meas_valid <= transition;
            if (transition) begin
                case (state)
                    ST_G:    Gmeas <= run_len;
                    ST_Y:    Ymeas <= run_len;
                    ST_R:    Rmeas <= run_len;
                    default: ;
                endcase
            end
            if (err_clr) begin
                dur_err    <= 1'b0;
                seq_err    <= 1'b0;
                onehot_err <= 1'b0;
                err_phase  <= 3'b000;
            end
            if (!code_legal) onehot_err <= 1'b1;
            if (seq_bad) seq_err <= 1'b1;
            if (dur_bad) begin
                dur_err   <= 1'b1;
                err_phase <= left_code;
            end
        end
    end

`ifdef TLS_MON_ROUND_EN
    // A round is complete at each red-to-green transition.
    // The counter wraps naturally at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_cnt <= 8'd0;
        end else if (Set) begin
            round_cnt <= 8'd0;
        end else if (transition && state == ST_R && state_next == ST_G) begin
            round_cnt <= round_cnt + 8'd1;
        end
    end
`else
    assign round_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tls_monitor.sv
// tb_tls_monitor
// --------------
// Directed testbench for tls_monitor. Light codes are applied one cycle at a
// time. Outputs are sampled 1 ns after each rising edge and compared against
// hand-computed values.
module tb_tls_monitor;

    localparam int W = 8;
    localparam logic [2:0] CG = 3'b100;
    localparam logic [2:0] CY = 3'b010;
    localparam logic [2:0] CR = 3'b001;

    logic         clk = 1'b0;
    logic         reset, Set, Stop, Jump, err_clr;
    logic [3:0]   Gin, Yin, Rin;
    logic         Gl, Yl, Rl;
    logic [W-1:0] Gmeas, Ymeas, Rmeas;
    logic         meas_valid, dur_err, seq_err, onehot_err;
    logic [2:0]   err_phase;
    logic [7:0]   round_cnt;

    int checks = 0;
    int errors = 0;
    int mv_count = 0;
    logic [7:0] exp_rounds;

    tls_monitor #(.W(W)) dut (
        .clk(clk), .reset(reset), .Set(Set), .Stop(Stop), .Jump(Jump),
        .Gin(Gin), .Yin(Yin), .Rin(Rin), .Gl(Gl), .Yl(Yl), .Rl(Rl),
        .err_clr(err_clr), .Gmeas(Gmeas), .Ymeas(Ymeas), .Rmeas(Rmeas),
        .meas_valid(meas_valid), .dur_err(dur_err), .seq_err(seq_err),
        .onehot_err(onehot_err), .err_phase(err_phase), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (meas_valid === 1'b1) mv_count++;

    task automatic drive_code(input logic [2:0] c, input int n);
        {Gl, Yl, Rl} = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; Set = 1'b0; Stop = 1'b0; Jump = 1'b0; err_clr = 1'b0;
        Gin = 4'd0; Yin = 4'd0; Rin = 4'd0; {Gl, Yl, Rl} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (Gmeas !== 8'd0 || Ymeas !== 8'd0 || Rmeas !== 8'd0) begin errors++; $display("[TB] FAIL reset_meas: got %0d/%0d/%0d expected 0/0/0", Gmeas, Ymeas, Rmeas); end
        checks++; if ({meas_valid, dur_err, seq_err, onehot_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {meas_valid, dur_err, seq_err, onehot_err}); end
        checks++; if (err_phase !== 3'b000 || round_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_phase_rounds: got %b/%0d expected 000/0", err_phase, round_cnt); end
        // Release reset with Set already high so the first edge programs 3/2/4.
        Gin = 4'd3; Yin = 4'd2; Rin = 4'd4; {Gl, Yl, Rl} = CG; Set = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        Set = 1'b0;
        checks++; if ({meas_valid, dur_err, seq_err, onehot_err} !== 4'b0000) begin errors++; $display("[TB] FAIL set_flags: got %b expected 0000", {meas_valid, dur_err, seq_err, onehot_err}); end
    endtask

    task automatic test_clean_round;
        mv_count = 0;
        drive_code(CG, 3);
        drive_code(CY, 1);
        checks++; if (meas_valid !== 1'b1) begin errors++; $display("[TB] FAIL clean_mv_pulse: got %b expected 1", meas_valid); end
        checks++; if (Gmeas !== 8'd3) begin errors++; $display("[TB] FAIL clean_gmeas_first: got %0d expected 3", Gmeas); end
        drive_code(CY, 1);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_mv_low: got %b expected 0", meas_valid); end
        drive_code(CR, 4);
        drive_code(CG, 3);
        drive_code(CY, 2);
        checks++; if (mv_count !== 4) begin errors++; $display("[TB] FAIL clean_mv_count: got %0d expected 4", mv_count); end
        checks++; if (Gmeas !== 8'd3 || Ymeas !== 8'd2 || Rmeas !== 8'd4) begin errors++; $display("[TB] FAIL clean_meas: got %0d/%0d/%0d expected 3/2/4", Gmeas, Ymeas, Rmeas); end
        checks++; if ({dur_err, seq_err, onehot_err} !== 3'b000) begin errors++; $display("[TB] FAIL clean_errs: got %b expected 000", {dur_err, seq_err, onehot_err}); end
    endtask

    task automatic test_dur_err;
        drive_code(CR, 4);
        drive_code(CG, 5);
        checks++; if (dur_err !== 1'b0) begin errors++; $display("[TB] FAIL dur_before: got %b expected 0", dur_err); end
        drive_code(CY, 1);
        checks++; if (dur_err !== 1'b1) begin errors++; $display("[TB] FAIL dur_set: got %b expected 1", dur_err); end
        checks++; if (err_phase !== CG) begin errors++; $display("[TB] FAIL dur_phase: got %b expected 100", err_phase); end
        checks++; if (Gmeas !== 8'd5) begin errors++; $display("[TB] FAIL dur_gmeas: got %0d expected 5", Gmeas); end
        err_clr = 1'b1;
        drive_code(CY, 1);
        err_clr = 1'b0;
        checks++; if (dur_err !== 1'b0 || err_phase !== 3'b000) begin errors++; $display("[TB] FAIL dur_clear: got %b/%b expected 0/000", dur_err, err_phase); end
    endtask

    task automatic test_jump;
        drive_code(CR, 4);
        drive_code(CG, 1);
        Jump = 1'b1;
        drive_code(CG, 1);
        Jump = 1'b0;
        drive_code(CR, 1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL jump_seq: got %b expected 0", seq_err); end
        checks++; if (dur_err !== 1'b0) begin errors++; $display("[TB] FAIL jump_dur: got %b expected 0", dur_err); end
        checks++; if (Gmeas !== 8'd2) begin errors++; $display("[TB] FAIL jump_gmeas: got %0d expected 2", Gmeas); end
        drive_code(CR, 3);
    endtask

    task automatic test_seq_err;
        drive_code(CG, 3);
        drive_code(CR, 1);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL seq_set: got %b expected 1", seq_err); end
        checks++; if (dur_err !== 1'b0 || Gmeas !== 8'd3) begin errors++; $display("[TB] FAIL seq_dur_gmeas: got %b/%0d expected 0/3", dur_err, Gmeas); end
        err_clr = 1'b1;
        drive_code(CR, 1);
        err_clr = 1'b0;
        checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL seq_clear: got %b expected 0", seq_err); end
        drive_code(CR, 2);
    endtask

    task automatic test_onehot;
        drive_code(CG, 3);
        drive_code(CY, 1);
        drive_code(3'b110, 1);
        checks++; if (onehot_err !== 1'b1) begin errors++; $display("[TB] FAIL onehot_set: got %b expected 1", onehot_err); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL onehot_seq: got %b expected 0", seq_err); end
        drive_code(CR, 1);
        checks++; if (Ymeas !== 8'd2 || dur_err !== 1'b0) begin errors++; $display("[TB] FAIL onehot_ymeas: got %0d/%b expected 2/0", Ymeas, dur_err); end
        err_clr = 1'b1;
        drive_code(CR, 1);
        checks++; if (onehot_err !== 1'b0) begin errors++; $display("[TB] FAIL onehot_clear: got %b expected 0", onehot_err); end
        // A clear coinciding with a new illegal code must leave the flag set.
        drive_code(3'b011, 1);
        err_clr = 1'b0;
        checks++; if (onehot_err !== 1'b1) begin errors++; $display("[TB] FAIL onehot_clr_race: got %b expected 1", onehot_err); end
        err_clr = 1'b1;
        drive_code(CR, 1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        reset = 1'b0;
        #2;
        checks++; if (Gmeas !== 8'd0 || Ymeas !== 8'd0 || Rmeas !== 8'd0) begin errors++; $display("[TB] FAIL midreset_meas: got %0d/%0d/%0d expected 0/0/0", Gmeas, Ymeas, Rmeas); end
        checks++; if ({meas_valid, dur_err, seq_err, onehot_err} !== 4'b0000 || err_phase !== 3'b000) begin errors++; $display("[TB] FAIL midreset_flags: got %b/%b expected 0000/000", {meas_valid, dur_err, seq_err, onehot_err}, err_phase); end
        @(posedge clk);
        #1;
        {Gl, Yl, Rl} = CG; Set = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        Set = 1'b0;
        // The first phase after Set is too long but must not be checked.
        drive_code(CG, 5);
        drive_code(CY, 1);
        checks++; if (Gmeas !== 8'd5 || dur_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_first: got %0d/%b expected 5/0", Gmeas, dur_err); end
        drive_code(CY, 1);
        drive_code(CR, 4);
        for (int i = 0; i < 2; i++) begin
            drive_code(CG, 3);
            drive_code(CY, 2);
            drive_code(CR, 4);
        end
        drive_code(CG, 1);
`ifdef TLS_MON_ROUND_EN
        exp_rounds = 8'd3;
`else
        exp_rounds = 8'd0;
`endif
        checks++; if (round_cnt !== exp_rounds) begin errors++; $display("[TB] FAIL rounds: got %0d expected %0d", round_cnt, exp_rounds); end
        checks++; if ({dur_err, seq_err, onehot_err} !== 3'b000 || Rmeas !== 8'd4) begin errors++; $display("[TB] FAIL rounds_clean: got %b/%0d expected 000/4", {dur_err, seq_err, onehot_err}, Rmeas); end
    endtask

    task automatic test_saturation;
        drive_code(CG, 299);
        drive_code(CY, 1);
        checks++; if (Gmeas !== 8'd255) begin errors++; $display("[TB] FAIL sat_gmeas: got %0d expected 255", Gmeas); end
        checks++; if (dur_err !== 1'b1 || err_phase !== CG) begin errors++; $display("[TB] FAIL sat_dur: got %b/%b expected 1/100", dur_err, err_phase); end
        Set = 1'b1;
        drive_code(CY, 1);
        Set = 1'b0;
        checks++; if (dur_err !== 1'b1 || Gmeas !== 8'd255) begin errors++; $display("[TB] FAIL set_keeps: got %b/%0d expected 1/255", dur_err, Gmeas); end
    endtask

    initial begin
        test_reset;
        test_clean_round;
        test_dur_err;
        test_jump;
        test_seq_err;
        test_onehot;
        test_reset_mid;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
